fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 21 ++
 rtl/fetch_ctrl_wait_timer.sv | 32 +++
 rtl/fetch_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction line fetch controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  // Bytes per instruction line (4 x 32-bit instructions).
  localparam int LINE_BYTES      = 16;
  // Default number of cycles tolerated without mem_rvalid.
  localparam int TIMEOUT_DEFAULT = 15;

  // Clears the byte offset within a line.
  function automatic logic [31:0] line_align(input logic [31:0] pc);
    return pc & ~32'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_ctrl_wait_timer.sv
// Response wait counter: cleared on entry to a waiting state, counts up while
// enabled and flags expiry once it has reached TIMEOUT.
module wait_timer
  import fetch_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  assign expired = (cnt_q == CW'(TIMEOUT));

  // Count waiting cycles; hold at TIMEOUT so the flag cannot wrap away.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction line fetch controller: issues one line read at a time to
// instruction memory and forwards the returned line to the fetch queue.
//
//   state | meaning
//   IDLE  | no request outstanding; waits for rd_req without abort
//   REQ   | mem_req held with a stable address until mem_gnt
//   WAIT  | granted, waiting for mem_rvalid; data goes to the queue
//   DROP  | granted but redirected; returning data is discarded
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       pc_in,
  input  logic              rd_req,
  input  logic              abort,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [LINE_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              err,
  output logic [15:0]       line_cnt
);

  state_t state_q, state_d;

  logic [31:0]       addr_q;
  logic              drop_q;
  logic [LINE_W-1:0] dout_q;
  logic              dv_q;
  logic              err_q;
  logic [15:0]       line_cnt_q;

  logic load_addr;
  logic set_drop;
  logic clr_drop;
  logic load_dout;
  logic set_err;
  logic timer_clr;
  logic timer_en;
  logic timer_expired;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and control strobes for the datapath registers.
  always_comb begin
    state_d   = state_q;
    load_addr = 1'b0;
    set_drop  = 1'b0;
    clr_drop  = 1'b0;
    load_dout = 1'b0;
    set_err   = 1'b0;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_clr = 1'b1;
        if (rd_req && !abort) begin
          load_addr = 1'b1;
          clr_drop  = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          // The grant commits memory to a response, so a redirect seen now
          // or earlier in REQ still has to swallow that response.
          timer_clr = 1'b1;
          clr_drop  = 1'b1;
          state_d   = (abort || drop_q) ? DROP : WAIT;
        end else if (abort) begin
          set_drop = 1'b1;
        end
      end
      WAIT: begin
        timer_en = 1'b1;
        if (mem_rvalid) begin
          load_dout = !abort;
          state_d   = IDLE;
        end else if (abort) begin
          timer_clr = 1'b1;
          state_d   = DROP;
        end else if (timer_expired) begin
          set_err = 1'b1;
          state_d = IDLE;
        end
      end
      DROP: begin
        timer_en = 1'b1;
        if (mem_rvalid) begin
          state_d = IDLE;
        end else if (timer_expired) begin
          set_err = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request address and pending-drop flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q <= '0;
      drop_q <= 1'b0;
    end else begin
      if (load_addr) begin
        addr_q <= line_align(pc_in);
      end
      if (clr_drop) begin
        drop_q <= 1'b0;
      end else if (set_drop) begin
        drop_q <= 1'b1;
      end
    end
  end

  // Returned line register, write strobe, sticky error and delivered count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dout_q     <= '0;
      dv_q       <= 1'b0;
      err_q      <= 1'b0;
      line_cnt_q <= '0;
    end else begin
      dv_q <= load_dout;
      if (load_dout) begin
        dout_q <= mem_rdata;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
      if (dout_valid) begin
        line_cnt_q <= line_cnt_q + 16'd1;
      end
    end
  end

  assign mem_req  = (state_q == REQ);
  assign mem_addr = addr_q;
  assign dout     = dout_q;
  // A redirect in the delivery cycle suppresses the write into the queue.
  assign dout_valid = dv_q & ~abort;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;
  assign line_cnt = line_cnt_q;

  // Request and address must stay put until memory accepts them.
  a_req_hold: assert property (@(posedge i_clk) disable iff (i_rst)
    (mem_req && !mem_gnt) |=> (mem_req && $stable(mem_addr)));

  // The queue write strobe is a single-cycle pulse.
  a_dv_pulse: assert property (@(posedge i_clk) disable iff (i_rst)
    dout_valid |=> !dout_valid);

  // A request is only ever raised from an idle controller.
  a_req_from_idle: assert property (@(posedge i_clk) disable iff (i_rst)
    (!mem_req ##1 mem_req) |-> $past(state_q) == IDLE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed memory handshakes with a
// scoreboard of lines that must reach the queue.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int LW = 128;

  localparam logic [LW-1:0] LINE_A = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [LW-1:0] LINE_B = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
  localparam logic [LW-1:0] LINE_C = 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004;
  localparam logic [LW-1:0] LINE_D = 128'hDDDD_0001_DDDD_0002_DDDD_0003_DDDD_0004;
  localparam logic [LW-1:0] LINE_E = 128'hEEEE_0001_EEEE_0002_EEEE_0003_EEEE_0004;
  localparam logic [LW-1:0] LINE_F = 128'hFFFF_0001_FFFF_0002_FFFF_0003_FFFF_0004;
  localparam logic [LW-1:0] LINE_G = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [LW-1:0] LINE_H = 128'h0BAD_F00D_DEAD_BEEF_CAFE_BABE_FEED_FACE;

  logic          i_clk;
  logic          i_rst;
  logic [31:0]   pc_in;
  logic          rd_req;
  logic          abort;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [LW-1:0] mem_rdata;
  logic [LW-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic          err;
  logic [15:0]   line_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] exp_line;

  fetch_ctrl #(
    .LINE_W  (LW),
    .TIMEOUT (15)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .pc_in      (pc_in),
    .rd_req     (rd_req),
    .abort      (abort),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .err        (err),
    .line_cnt   (line_cnt)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] exp_addr);
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      seen = mem_req;
    end
    chk("req_seen", 128'(seen), 128'd1);
    chk("mem_addr", 128'(mem_addr), 128'(exp_addr));
  endtask

  task automatic grant(input int dly);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("req_hold", 128'(mem_req), 128'd1);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
  endtask

  task automatic respond(input logic [LW-1:0] line, input int dly, input bit deliver);
    for (int i = 1; i < dly; i++) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = line;
    if (deliver) exp_q.push_back(line);
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [LW-1:0] line);
    pc_in  = pc;
    rd_req = 1'b1;
    wait_req(pc & 32'hFFFF_FFF0);
    rd_req = 1'b0;
    grant(0);
    respond(line, 1, 1'b1);
    tick();
  endtask

  // Scoreboard: every queue write must match the oldest expected line.
  always @(negedge i_clk) begin
    if (dout_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dout_valid", 128'(dout_valid), 128'd0);
      end else begin
        exp_line = exp_q.pop_front();
        chk("dout", dout, exp_line);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_rst      = 1'b1;
    pc_in      = '0;
    rd_req     = 1'b0;
    abort      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    repeat (2) tick();

    chk("rst_mem_req",  128'(mem_req), 128'd0);
    chk("rst_mem_addr", 128'(mem_addr), 128'd0);
    chk("rst_dout",     dout, 128'd0);
    chk("rst_dv",       128'(dout_valid), 128'd0);
    chk("rst_busy",     128'(busy), 128'd0);
    chk("rst_err",      128'(err), 128'd0);
    chk("rst_line_cnt", 128'(line_cnt), 128'd0);
    i_rst = 1'b0;
    tick();

    // Basic fetch: grant after one cycle, data three cycles after grant.
    pc_in  = 32'h0000_0108;
    rd_req = 1'b1;
    wait_req(32'h0000_0100);
    rd_req = 1'b0;
    grant(1);
    respond(LINE_A, 3, 1'b1);
    chk("basic_dv", 128'(dout_valid), 128'd1);
    tick();
    chk("basic_dv_pulse", 128'(dout_valid), 128'd0);
    chk("basic_line_cnt", 128'(line_cnt), 128'd1);
    chk("basic_busy",     128'(busy), 128'd0);
    tick();
    chk("basic_dout_hold", dout, LINE_A);

    // Abort one cycle after grant, data two cycles later is dropped.
    pc_in  = 32'h0000_2004;
    rd_req = 1'b1;
    wait_req(32'h0000_2000);
    rd_req = 1'b0;
    grant(0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abw_state_drop", 128'(dut.state_q), 128'(DROP));
    chk("abw_busy", 128'(busy), 128'd1);
    tick();
    respond(LINE_B, 1, 1'b0);
    chk("abw_state_idle", 128'(dut.state_q), 128'(IDLE));
    chk("abw_dv", 128'(dout_valid), 128'd0);
    tick();
    chk("abw_line_cnt", 128'(line_cnt), 128'd1);

    // Abort and rvalid together in WAIT.
    pc_in  = 32'h0000_2100;
    rd_req = 1'b1;
    wait_req(32'h0000_2100);
    rd_req = 1'b0;
    grant(0);
    abort      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = LINE_C;
    tick();
    abort      = 1'b0;
    mem_rvalid = 1'b0;
    chk("sim_state_idle", 128'(dut.state_q), 128'(IDLE));
    chk("sim_dv", 128'(dout_valid), 128'd0);
    tick();
    chk("sim_line_cnt", 128'(line_cnt), 128'd1);
    chk("sim_dout_hold", dout, LINE_A);

    // Abort in the delivery cycle suppresses the queue write.
    pc_in  = 32'h0000_2400;
    rd_req = 1'b1;
    wait_req(32'h0000_2400);
    rd_req = 1'b0;
    grant(0);
    respond(LINE_D, 1, 1'b0);
    abort = 1'b1;
    #1;
    chk("gate_dv", 128'(dout_valid), 128'd0);
    tick();
    abort = 1'b0;
    chk("gate_line_cnt", 128'(line_cnt), 128'd1);

    // Abort in REQ before the grant: address kept, grant leads to DROP.
    pc_in  = 32'h0000_3010;
    rd_req = 1'b1;
    wait_req(32'h0000_3010);
    rd_req = 1'b0;
    abort  = 1'b1;
    tick();
    abort  = 1'b0;
    chk("abr_state_req", 128'(dut.state_q), 128'(REQ));
    chk("abr_addr_kept", 128'(mem_addr), 128'h3010);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("abr_state_drop", 128'(dut.state_q), 128'(DROP));
    chk("abr_mem_req", 128'(mem_req), 128'd0);
    respond(LINE_E, 1, 1'b0);
    chk("abr_state_idle", 128'(dut.state_q), 128'(IDLE));
    tick();
    chk("abr_line_cnt", 128'(line_cnt), 128'd1);

    // Timeout: granted request never answered.
    pc_in  = 32'h0000_4000;
    rd_req = 1'b1;
    wait_req(32'h0000_4000);
    rd_req = 1'b0;
    grant(0);
    repeat (14) tick();
    chk("to_err_early", 128'(err), 128'd0);
    chk("to_busy_early", 128'(busy), 128'd1);
    n = 0;
    while (busy && n < 6) begin
      tick();
      n++;
    end
    chk("to_left_wait", 128'(busy), 128'd0);
    chk("to_err", 128'(err), 128'd1);
    chk("to_state_idle", 128'(dut.state_q), 128'(IDLE));
    respond(LINE_F, 1, 1'b0);
    chk("to_stale_dv", 128'(dout_valid), 128'd0);
    chk("to_stale_state", 128'(dut.state_q), 128'(IDLE));
    tick();
    chk("to_stale_line_cnt", 128'(line_cnt), 128'd1);
    fetch(32'h0000_5000, LINE_G);
    chk("to_err_held", 128'(err), 128'd1);
    chk("to_after_line_cnt", 128'(line_cnt), 128'd2);

    // Back-to-back fetches from a fresh reset.
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    tick();
    chk("b2b_line_cnt0", 128'(line_cnt), 128'd0);
    chk("b2b_err_clr", 128'(err), 128'd0);
    mem_gnt = 1'b1;
    rd_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [LW-1:0] ln;
      ln = {4{32'h6000_0000 + 32'(k)}};
      pc_in = 32'h0000_600C + 32'(k * 16);
      wait_req(32'h0000_6000 + 32'(k * 16));
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = ln;
      exp_q.push_back(ln);
      tick();
      mem_rvalid = 1'b0;
    end
    rd_req  = 1'b0;
    mem_gnt = 1'b0;
    tick();
    chk("b2b_line_cnt4", 128'(line_cnt), 128'd4);

    // Delivered-line counter wraps.
    force dut.line_cnt_q = 16'hFFFF;
    tick();
    release dut.line_cnt_q;
    chk("wrap_preload", 128'(line_cnt), 128'hFFFF);
    fetch(32'h0000_6800, LINE_H);
    chk("wrap_line_cnt", 128'(line_cnt), 128'd0);

    // Reset asserted while waiting for data.
    pc_in  = 32'h0000_7000;
    rd_req = 1'b1;
    wait_req(32'h0000_7000);
    rd_req = 1'b0;
    grant(0);
    tick();
    i_rst = 1'b1;
    #1;
    chk("mid_state", 128'(dut.state_q), 128'(IDLE));
    chk("mid_mem_req", 128'(mem_req), 128'd0);
    chk("mid_mem_addr", 128'(mem_addr), 128'd0);
    chk("mid_dout", dout, 128'd0);
    chk("mid_dv", 128'(dout_valid), 128'd0);
    chk("mid_busy", 128'(busy), 128'd0);
    chk("mid_line_cnt", 128'(line_cnt), 128'd0);
    tick();
    i_rst = 1'b0;
    tick();
    respond(LINE_A, 1, 1'b0);
    chk("mid_stale_dv", 128'(dout_valid), 128'd0);
    chk("mid_stale_state", 128'(dut.state_q), 128'(IDLE));
    tick();
    chk("mid_stale_line_cnt", 128'(line_cnt), 128'd0);
    fetch(32'h0000_8008, LINE_B);
    chk("mid_after_line_cnt", 128'(line_cnt), 128'd1);

    repeat (3) tick();
    chk("sb_empty", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
